// File: rtl/pc_word_serializer.sv
// pc_word_serializer: captures the alpha/beta/v vectors on start and
// streams them out as 32-bit words over a valid/ready handshake.
module pc_word_serializer #(
  parameter string PARAMETER_SET = "L1",
  parameter int    T = (PARAMETER_SET == "L5") ? 4 : 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [32*T-1:0] i_alpha,
  input  logic [32*T-1:0] i_beta,
  input  logic [32*T-1:0] i_v,
  output logic [31:0]     o_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_last,
  output logic            o_busy,
  output logic            o_done
);

  localparam int N  = 3 * T;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [32*T-1:0] alpha_q, beta_q, v_q;
  logic            load;

  logic [31:0] words [N];

  // Flatten the shadow vectors into stream order: alpha, beta, v.
  for (genvar j = 0; j < T; j++) begin : g_words
    assign words[j]       = alpha_q[32*j +: 32];
    assign words[T + j]   = beta_q[32*j +: 32];
    assign words[2*T + j] = v_q[32*j +: 32];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      alpha_q <= '0;
      beta_q  <= '0;
      v_q     <= '0;
    end else if (load) begin
      alpha_q <= i_alpha;
      beta_q  <= i_beta;
      v_q     <= i_v;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    o_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        o_last  = (cnt_q == LAST);
        o_data  = words[cnt_q];
        // Counter parks on the last index; DONE takes over from there.
        if (i_ready) begin
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
